// File: rtl/sudoku_cursor_ctrl.sv
// Backtracking turn sequencer for the sudoku grid: walks the 81 tiles in
// row-major order, hands the turn to one tile at a time and backtracks on failure.
module sudoku_cursor_ctrl #(
    parameter int LEN    = 3,
    parameter int STEP_W = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              cursor_given,
    input  logic              tile_done,
    input  logic              tile_pass,
    output logic              turn_valid,
    output logic              turn_dir,
    output logic [3:0]        cursor_row,
    output logic [3:0]        cursor_col,
    output logic              busy,
    output logic              done_success,
    output logic              done_failure,
    output logic [STEP_W-1:0] step_count
);

    localparam int         SIDE = LEN * LEN;
    localparam logic [3:0] LAST = 4'(SIDE - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SUCCESS,
        FAILURE
    } state_t;

    state_t              r_state;
    logic [3:0]          r_row;
    logic [3:0]          r_col;
    logic                r_dir;
    logic [STEP_W-1:0]   r_step;
    logic                r_busy;
    logic                r_done_s;
    logic                r_done_f;

    state_t              w_state_next;
    logic [3:0]          w_row_next;
    logic [3:0]          w_col_next;
    logic                w_dir_next;
    logic [STEP_W-1:0]   w_step_next;
    logic                w_turn;

    logic                w_at_first;
    logic                w_at_last;
    logic [3:0]          w_adv_row;
    logic [3:0]          w_adv_col;
    logic [3:0]          w_ret_row;
    logic [3:0]          w_ret_col;

    assign w_at_first = (r_row == 4'd0) && (r_col == 4'd0);
    assign w_at_last  = (r_row == LAST) && (r_col == LAST);

    // Row-major neighbours; the terminal cases are handled before these are used.
    assign w_adv_col = (r_col == LAST) ? 4'd0 : r_col + 4'd1;
    assign w_adv_row = (r_col == LAST) ? r_row + 4'd1 : r_row;
    assign w_ret_col = (r_col == 4'd0) ? LAST : r_col - 4'd1;
    assign w_ret_row = (r_col == 4'd0) ? r_row - 4'd1 : r_row;

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_col_next   = r_col;
        w_dir_next   = r_dir;
        w_step_next  = r_step;
        w_turn       = 1'b0;

        case (r_state)
            IDLE, SUCCESS, FAILURE: begin
                if (start) begin
                    w_state_next = ISSUE;
                    w_row_next   = 4'd0;
                    w_col_next   = 4'd0;
                    w_dir_next   = 1'b0;
                    w_step_next  = '0;
                end
            end

            ISSUE: begin
                if (!cursor_given) begin
                    w_turn       = 1'b1;
                    w_state_next = WAIT;
                    if (r_step != {STEP_W{1'b1}}) begin
                        w_step_next = r_step + 1'b1;
                    end
                end else if (!r_dir) begin
                    // Given clue: skip it in the direction we are travelling.
                    if (w_at_last) begin
                        w_state_next = SUCCESS;
                    end else begin
                        w_row_next = w_adv_row;
                        w_col_next = w_adv_col;
                    end
                end else begin
                    if (w_at_first) begin
                        w_state_next = FAILURE;
                    end else begin
                        w_row_next = w_ret_row;
                        w_col_next = w_ret_col;
                    end
                end
            end

            WAIT: begin
                if (tile_done) begin
                    if (tile_pass) begin
                        if (w_at_last) begin
                            w_state_next = SUCCESS;
                        end else begin
                            w_state_next = ISSUE;
                            w_row_next   = w_adv_row;
                            w_col_next   = w_adv_col;
                            w_dir_next   = 1'b0;
                        end
                    end else begin
                        if (w_at_first) begin
                            w_state_next = FAILURE;
                        end else begin
                            w_state_next = ISSUE;
                            w_row_next   = w_ret_row;
                            w_col_next   = w_ret_col;
                            w_dir_next   = 1'b1;
                        end
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_row    <= 4'd0;
            r_col    <= 4'd0;
            r_dir    <= 1'b0;
            r_step   <= '0;
            r_busy   <= 1'b0;
            r_done_s <= 1'b0;
            r_done_f <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_row    <= w_row_next;
            r_col    <= w_col_next;
            r_dir    <= w_dir_next;
            r_step   <= w_step_next;
            r_busy   <= (w_state_next == ISSUE) || (w_state_next == WAIT);
            r_done_s <= (w_state_next == SUCCESS);
            r_done_f <= (w_state_next == FAILURE);
        end
    end

    assign turn_valid   = w_turn;
    assign turn_dir     = r_dir;
    assign cursor_row   = r_row;
    assign cursor_col   = r_col;
    assign busy         = r_busy;
    assign done_success = r_done_s;
    assign done_failure = r_done_f;
    assign step_count   = r_step;

endmodule

// File: tb/tb_sudoku_cursor_ctrl.sv
// Directed bench for sudoku_cursor_ctrl: an index-based backtracking model
// queues the expected turns, which are popped as the DUT grants them.
module tb_sudoku_cursor_ctrl;

    localparam int STEP_W = 24;

    logic              clock;
    logic              reset;
    logic              start;
    logic              cursor_given;
    logic              tile_done;
    logic              tile_pass;
    logic              turn_valid;
    logic              turn_dir;
    logic [3:0]        cursor_row;
    logic [3:0]        cursor_col;
    logic              busy;
    logic              done_success;
    logic              done_failure;
    logic [STEP_W-1:0] step_count;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] c;
        logic       d;
    } turn_t;

    bit    given [81];
    bit    vq [$];
    turn_t exp_q [$];
    int    total = 0;
    int    bad   = 0;

    sudoku_cursor_ctrl #(.LEN(3), .STEP_W(STEP_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .cursor_given (cursor_given),
        .tile_done    (tile_done),
        .tile_pass    (tile_pass),
        .turn_valid   (turn_valid),
        .turn_dir     (turn_dir),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col),
        .busy         (busy),
        .done_success (done_success),
        .done_failure (done_failure),
        .step_count   (step_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        cursor_given = 1'b0;
        if (cursor_row < 4'd9 && cursor_col < 4'd9)
            cursor_given = given[int'(cursor_row) * 9 + int'(cursor_col)];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_row"},  32'(cursor_row), 0);
        check({tag, "_col"},  32'(cursor_col), 0);
        check({tag, "_dir"},  32'(turn_dir), 0);
        check({tag, "_step"}, 32'(step_count), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_succ"}, 32'(done_success), 0);
        check({tag, "_fail"}, 32'(done_failure), 0);
        check({tag, "_tv"},   32'(turn_valid), 0);
    endtask

    // Runs one solve. lat_exp >= 0 checks cycles from start edge to first turn;
    // stop_idx >= 0 returns at the negedge where that tile is granted the turn.
    task automatic run(input string tag, input int lat_exp, input int stop_idx);
        turn_t t;
        bit    exp_succ;
        int    exp_steps;
        int    idx;
        bit    dir;
        bit    vcopy [$];
        bit    v;
        bit    pending;
        bit    seen_first;
        int    cyc;
        int    turns;

        vcopy = vq;
        idx = 0;
        dir = 1'b0;
        exp_steps = 0;
        exp_succ = 1'b0;
        exp_q.delete();
        for (int it = 0; it < 5000; it++) begin
            if (idx >= 81) begin exp_succ = 1'b1; break; end
            if (idx < 0) begin exp_succ = 1'b0; break; end
            if (given[idx]) begin
                idx = dir ? idx - 1 : idx + 1;
                continue;
            end
            t.r = 4'(idx / 9);
            t.c = 4'(idx % 9);
            t.d = dir;
            exp_q.push_back(t);
            exp_steps++;
            v = (vcopy.size() > 0) ? vcopy.pop_front() : 1'b1;
            if (v) begin idx++; dir = 1'b0; end
            else   begin idx--; dir = 1'b1; end
        end

        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        pending = 1'b0;
        seen_first = 1'b0;
        turns = 0;
        while (1) begin
            cyc++;
            tile_done = 1'b0;
            if (cyc > 3000) begin
                check({tag, "_timeout_done"}, 32'(done_success | done_failure), 1);
                break;
            end
            if (pending) begin
                check({tag, "_step_after_turn"}, 32'(step_count), 32'(turns));
                check({tag, "_busy_wait"}, 32'(busy), 1);
                v = (vq.size() > 0) ? vq.pop_front() : 1'b1;
                tile_done = 1'b1;
                tile_pass = v;
                pending = 1'b0;
            end else if (turn_valid) begin
                if (!seen_first && lat_exp >= 0)
                    check({tag, "_latency"}, 32'(cyc), 32'(lat_exp));
                seen_first = 1'b1;
                check({tag, "_turn_expected"}, 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    t = exp_q.pop_front();
                    total++;
                    assert (cursor_row === t.r && cursor_col === t.c && turn_dir === t.d) else begin
                        bad++;
                        $error("FAIL %s_turn got=(%0d,%0d,d%0d) exp=(%0d,%0d,d%0d)", tag,
                               cursor_row, cursor_col, turn_dir, t.r, t.c, t.d);
                    end
                end
                turns++;
                pending = 1'b1;
                if (stop_idx >= 0 && int'(cursor_row) * 9 + int'(cursor_col) == stop_idx)
                    return;
            end else if (done_success || done_failure) begin
                check({tag, "_succ"}, 32'(done_success), 32'(exp_succ));
                check({tag, "_fail"}, 32'(done_failure), 32'(!exp_succ));
                check({tag, "_steps"}, 32'(step_count), 32'(exp_steps));
                check({tag, "_row"}, 32'(cursor_row), exp_succ ? 8 : 0);
                check({tag, "_col"}, 32'(cursor_col), exp_succ ? 8 : 0);
                check({tag, "_busy_done"}, 32'(busy), 0);
                check({tag, "_left"}, 32'(exp_q.size()), 0);
                $display("txn %s: turns=%0d step_count=%0d succ=%0d fail=%0d",
                         tag, turns, step_count, done_success, done_failure);
                break;
            end
            @(negedge clock);
        end
        tile_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        tile_done = 1'b0;
        tile_pass = 1'b0;
        for (int i = 0; i < 81; i++) given[i] = 1'b0;
        #1;
        check_reset_vals("por");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals("idle");

        vq.delete();
        run("all_pass", 1, -1);

        vq = '{1'b0};
        run("first_fail", 1, -1);

        vq = '{1'b1, 1'b1, 1'b0, 1'b1};
        run("backtrack", 1, -1);

        for (int i = 0; i < 9; i++) given[i] = 1'b1;
        vq.delete();
        run("row0_given", 10, -1);

        vq = '{1'b0};
        run("row0_given_fail", 10, -1);
        for (int i = 0; i < 9; i++) given[i] = 1'b0;

        vq.delete();
        run("mid_reset", 1, 31);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("wait_start_busy", 32'(busy), 1);
        check("wait_start_row", 32'(cursor_row), 3);
        check("wait_start_col", 32'(cursor_col), 4);
        check("wait_start_step", 32'(step_count), 32);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        $display("txn async_rst: row=%0d col=%0d step=%0d", cursor_row, cursor_col, step_count);
        @(negedge clock);
        reset = 1'b0;

        vq.delete();
        run("after_reset", 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
